// File: rtl/ft600_rx_deframer.sv
// Receive deframer behind the FT600 bus interface: word FIFO with read throttle,
// then a header/body splitter that turns length-prefixed packets into a valid/ready stream.

module ft600_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int SKID  = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        push_req,
    input  logic [15:0] push_data,
    input  logic        pop,
    output logic [15:0] head,
    output logic        empty,
    output logic        full,
    output logic        throttle
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] SKID_C  = (AW + 1)'(SKID);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    // A full FIFO refuses the word even if a pop frees a slot in the same cycle.
    assign push_ok  = push_req && !full;
    assign pop_ok   = pop && !empty;
    assign head     = mem[rd_ptr];
    assign throttle = (DEPTH_C - count) <= SKID_C;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// state  | meaning
// HEADER | waiting for a length word; zero lengths are counted and skipped
// BODY   | forwarding 'remaining' payload words to the consumer
module ft600_rx_deframer #(
    parameter int DEPTH = 16,
    parameter int SKID  = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_throttle,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        overflow,
    output logic [7:0]  zero_len_cnt,
    output logic [15:0] pkt_cnt
);

    localparam logic [0:0] HEADER = 1'b0;
    localparam logic [0:0] BODY   = 1'b1;

    logic [0:0]  state;
    logic [15:0] remaining;
    logic [15:0] head;
    logic        empty;
    logic        full;
    logic        fifo_pop;

    ft600_rx_fifo #(
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push_req  (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .throttle  (in_throttle)
    );

    assign out_valid = (state == BODY) && !empty;
    // Data is zeroed while idle so stale RAM contents never show on the bus.
    assign out_data  = out_valid ? head : 16'h0000;
    assign out_last  = out_valid && (remaining == 16'd1);
    assign fifo_pop  = (state == HEADER) ? !empty : (out_valid && out_ready);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state        <= HEADER;
            remaining    <= 16'd0;
            overflow     <= 1'b0;
            zero_len_cnt <= 8'd0;
            pkt_cnt      <= 16'd0;
        end else begin
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
            case (state)
                HEADER: begin
                    if (!empty) begin
                        if (head == 16'd0) begin
                            if (zero_len_cnt != 8'hFF) begin
                                zero_len_cnt <= zero_len_cnt + 1'b1;
                            end
                        end else begin
                            remaining <= head;
                            state     <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (out_valid && out_ready) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == 16'd1) begin
                            pkt_cnt <= pkt_cnt + 1'b1;
                            state   <= HEADER;
                        end
                    end
                end
                default: state <= HEADER;
            endcase
        end
    end

endmodule

// File: tb/tb_ft600_rx_deframer.sv
// Directed bench for ft600_rx_deframer (DEPTH=16, SKID=4): reset, framing,
// throttle/overflow, zero-length headers, mid-packet reset and pointer wrap.

module tb_ft600_rx_deframer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_throttle;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        overflow;
    logic [7:0]  zero_len_cnt;
    logic [15:0] pkt_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] got_d[$];
    logic        got_l[$];

    ft600_rx_deframer #(.DEPTH(16), .SKID(4)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_throttle  (in_throttle),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .zero_len_cnt (zero_len_cnt),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 CLK = ~CLK;

    // Called 1 time unit after a rising edge: drive, record any transfer, advance one cycle.
    task automatic cyc(input logic v, input logic [15:0] d, input logic rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        got_d.delete();
        got_l.delete();
    endtask

    task automatic test_reset();
        nRST      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0002;
        out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({in_throttle, out_valid, out_last, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {in_throttle, out_valid, out_last, overflow});
        end
        checks++;
        if ({out_data, zero_len_cnt, pkt_cnt} !== 40'h0) begin
            errors++;
            $display("FAIL reset_values: data=%h zlc=%h pkt=%h expected all 0", out_data, zero_len_cnt, pkt_cnt);
        end
        nRST = 1'b1;
        got_d.delete();
        got_l.delete();
        cyc(1'b1, 16'h0001, 1'b1);
        cyc(1'b1, 16'h0077, 1'b1);
        repeat (4) cyc(1'b0, 16'h0000, 1'b1);
        checks++;
        if (got_d.size() != 1) begin
            errors++;
            $display("FAIL reset_first_header_count: got %0d words expected 1", got_d.size());
        end
        for (int i = 0; i < got_d.size() && i < 1; i++) begin
            checks++;
            if (got_d[i] !== 16'h0077 || got_l[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_first_header_word: got %h/%b expected 0077/1", got_d[i], got_l[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 16'd1) begin
            errors++;
            $display("FAIL reset_pkt_cnt: got %0d expected 1", pkt_cnt);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_d [3];
        exp_d = '{16'h00A1, 16'h00B2, 16'h00C3};
        do_reset();
        cyc(1'b1, 16'h0003, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, exp_d[i], 1'b1);
        repeat (5) cyc(1'b0, 16'h0000, 1'b1);
        checks++;
        if (got_d.size() != 3) begin
            errors++;
            $display("FAIL basic_count: got %0d words expected 3", got_d.size());
        end
        for (int i = 0; i < got_d.size() && i < 3; i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin
                errors++;
                $display("FAIL basic_word%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_d[i], (i == 2));
            end
        end
        checks++;
        if (pkt_cnt !== 16'd1) begin
            errors++;
            $display("FAIL basic_pkt_cnt: got %0d expected 1", pkt_cnt);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        cyc(1'b1, 16'h0010, 1'b0);
        for (int i = 0; i < 11; i++) cyc(1'b1, 16'(16'h3000 + i), 1'b0);
        checks++;
        if (in_throttle !== 1'b0) begin
            errors++;
            $display("FAIL throttle_at_11: got %b expected 0", in_throttle);
        end
        cyc(1'b1, 16'h300B, 1'b0);
        checks++;
        if (in_throttle !== 1'b1) begin
            errors++;
            $display("FAIL throttle_at_12: got %b expected 1", in_throttle);
        end
        for (int i = 12; i < 16; i++) cyc(1'b1, 16'(16'h3000 + i), 1'b0);
        checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h3000 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL full_no_overflow: got ovf=%b v=%b d=%h l=%b expected 0/1/3000/0",
                     overflow, out_valid, out_data, out_last);
        end
        cyc(1'b1, 16'h3FFF, 1'b0);
        checks++;
        if (overflow !== 1'b1 || out_data !== 16'h3000) begin
            errors++;
            $display("FAIL drop_17th: got ovf=%b d=%h expected 1/3000", overflow, out_data);
        end
        cyc(1'b1, 16'h0BAD, 1'b1);
        repeat (20) cyc(1'b0, 16'h0000, 1'b1);
        checks++;
        if (got_d.size() != 16) begin
            errors++;
            $display("FAIL fill_count: got %0d words expected 16", got_d.size());
        end
        for (int i = 0; i < got_d.size() && i < 16; i++) begin
            checks++;
            if (got_d[i] !== 16'(16'h3000 + i) || got_l[i] !== (i == 15)) begin
                errors++;
                $display("FAIL fill_word%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], 16'(16'h3000 + i), (i == 15));
            end
        end
        checks++;
        if (overflow !== 1'b1 || pkt_cnt !== 16'd1) begin
            errors++;
            $display("FAIL fill_sticky: got ovf=%b pkt=%0d expected 1/1", overflow, pkt_cnt);
        end
        cyc(1'b1, 16'h0001, 1'b1);
        cyc(1'b1, 16'h0055, 1'b1);
        repeat (3) cyc(1'b0, 16'h0000, 1'b1);
        checks++;
        if (got_d.size() != 17 || pkt_cnt !== 16'd2) begin
            errors++;
            $display("FAIL full_pop_push_rejected: got %0d words pkt=%0d expected 17/2", got_d.size(), pkt_cnt);
        end else begin
            checks++;
            if (got_d[16] !== 16'h0055 || got_l[16] !== 1'b1) begin
                errors++;
                $display("FAIL after_full_word: got %h/%b expected 0055/1", got_d[16], got_l[16]);
            end
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        cyc(1'b1, 16'h0000, 1'b1);
        cyc(1'b1, 16'h0001, 1'b1);
        cyc(1'b1, 16'h00D4, 1'b1);
        repeat (4) cyc(1'b0, 16'h0000, 1'b1);
        checks++;
        if (zero_len_cnt !== 8'd1) begin
            errors++;
            $display("FAIL zero_len_cnt: got %0d expected 1", zero_len_cnt);
        end
        checks++;
        if (got_d.size() != 1 || pkt_cnt !== 16'd1) begin
            errors++;
            $display("FAIL zero_len_pkt: got %0d words pkt=%0d expected 1/1", got_d.size(), pkt_cnt);
        end
        for (int i = 0; i < got_d.size() && i < 1; i++) begin
            checks++;
            if (got_d[i] !== 16'h00D4 || got_l[i] !== 1'b1) begin
                errors++;
                $display("FAIL zero_len_word: got %h/%b expected 00D4/1", got_d[i], got_l[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        cyc(1'b1, 16'h0004, 1'b0);
        cyc(1'b1, 16'h00F0, 1'b0);
        cyc(1'b1, 16'h00F1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        nRST = 1'b0;
        cyc(1'b0, 16'h0000, 1'b0);
        nRST = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid: got %b expected 0", out_valid);
        end
        cyc(1'b1, 16'h0001, 1'b1);
        cyc(1'b1, 16'h00E5, 1'b1);
        repeat (4) cyc(1'b0, 16'h0000, 1'b1);
        checks++;
        if (got_d.size() != 1 || pkt_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midreset_pkt: got %0d words pkt=%0d expected 1/1", got_d.size(), pkt_cnt);
        end
        for (int i = 0; i < got_d.size() && i < 1; i++) begin
            checks++;
            if (got_d[i] !== 16'h00E5 || got_l[i] !== 1'b1) begin
                errors++;
                $display("FAIL midreset_word: got %h/%b expected 00E5/1", got_d[i], got_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        cyc(1'b1, 16'd20, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b1, 16'(16'h6000 + i), 1'b0);
        checks++;
        if (in_throttle !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_at_15: got thr=%b ovf=%b expected 1/0", in_throttle, overflow);
        end
        cyc(1'b1, 16'h600F, 1'b1);
        cyc(1'b1, 16'h6010, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_simul_count: got ovf=%b expected 0", overflow);
        end
        cyc(1'b0, 16'h0000, 1'b1);
        for (int i = 17; i < 20; i++) cyc(1'b1, 16'(16'h6000 + i), 1'b1);
        repeat (20) cyc(1'b0, 16'h0000, 1'b1);
        checks++;
        if (got_d.size() != 20 || pkt_cnt !== 16'd1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_totals: got %0d words pkt=%0d ovf=%b expected 20/1/0", got_d.size(), pkt_cnt, overflow);
        end
        for (int i = 0; i < got_d.size() && i < 20; i++) begin
            checks++;
            if (got_d[i] !== 16'(16'h6000 + i) || got_l[i] !== (i == 19)) begin
                errors++;
                $display("FAIL wrap_word%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], 16'(16'h6000 + i), (i == 19));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_zero_len();
        test_reset_mid_packet();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
